// File: rtl/ref_slew_l1.sv
// ref_slew_l1 -- slew-rate limited reference generator.
//
// Moves the registered output `out` toward `target` by at most `step` per
// `ce` strobe, clamping on the final step so it never overshoots. The
// arithmetic is done one bit wider than the ports, so it cannot wrap for any
// signed target/out pair.
//
// Per-cycle priority: resetn low > preset > hold > ce ramp update > no change.
//
// Handshake note: there is no valid/ready pair on this block. `ce` is a
// single-cycle strobe that is acted on at the rising edge where it is sampled
// high. `out`, `settled` and `state` are registered and change one clock
// after that edge.
//
// Ports:
//   aclk     in   system clock, rising edge
//   resetn   in   synchronous active-low reset
//   ce       in   one-cycle update strobe (slew step rate)
//   target   in   signed requested reference value
//   step     in   unsigned max change of out per ce; the MSB is ignored
//   hold     in   freeze out at its current value
//   preset   in   load out with target immediately
//   out      out  signed slew-limited reference
//   settled  out  high when out equals target (registered with out)
//   state    out  FSM state: 0 IDLE, 1 UP, 2 DOWN, 3 FROZEN
module ref_slew_l1 #(
  parameter int DATA_WIDTH         = 32,
  parameter int DATA_WIDTH_DECIMAL = 22
) (
  input  logic                         aclk,
  input  logic                         resetn,
  input  logic                         ce,
  input  logic signed [DATA_WIDTH-1:0] target,
  input  logic        [DATA_WIDTH-1:0] step,
  input  logic                         hold,
  input  logic                         preset,
  output logic signed [DATA_WIDTH-1:0] out,
  output logic                         settled,
  output logic        [1:0]            state
);

  // The fractional width only fixes how the fixed-point words are read.
  // It does not change the arithmetic, so it is only sanity-checked here.
  if (DATA_WIDTH_DECIMAL < 0 || DATA_WIDTH_DECIMAL >= DATA_WIDTH) begin : g_bad_frac
    $error("ref_slew_l1: DATA_WIDTH_DECIMAL must lie in [0, DATA_WIDTH-1]");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UP     = 2'd1,
    ST_DOWN   = 2'd2,
    ST_FROZEN = 2'd3
  } state_t;

  state_t st;

  // Step magnitude with the MSB forced to zero, so it stays non-negative.
  logic [DATA_WIDTH-1:0] step_eff;
  assign step_eff = step & {1'b0, {(DATA_WIDTH-1){1'b1}}};

  // Widened operands: out and target are sign-extended, and step is
  // zero-extended. The sum or difference then always fits.
  logic signed [DATA_WIDTH:0] out_ext;
  logic signed [DATA_WIDTH:0] tgt_ext;
  logic signed [DATA_WIDTH:0] step_ext;
  logic signed [DATA_WIDTH:0] up_sum;
  logic signed [DATA_WIDTH:0] dn_diff;
  logic signed [DATA_WIDTH-1:0] up_next;
  logic signed [DATA_WIDTH-1:0] dn_next;

  assign out_ext  = {out[DATA_WIDTH-1], out};
  assign tgt_ext  = {target[DATA_WIDTH-1], target};
  assign step_ext = {1'b0, step_eff};
  assign up_sum   = out_ext + step_ext;
  assign dn_diff  = out_ext - step_ext;

  // Clamp to target. In range, the truncated wide value is exact.
  assign up_next = (up_sum  > tgt_ext) ? target : up_sum[DATA_WIDTH-1:0];
  assign dn_next = (dn_diff < tgt_ext) ? target : dn_diff[DATA_WIDTH-1:0];

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      out     <= '0;
      settled <= 1'b0;
      st      <= ST_IDLE;
    end else if (preset) begin
      out     <= target;
      settled <= 1'b1;
      st      <= ST_IDLE;
    end else if (hold) begin
      settled <= (out == target);
      st      <= ST_FROZEN;
    end else if (ce) begin
      if (out < target) begin
        out     <= up_next;
        settled <= (up_next == target);
        st      <= ST_UP;
      end else if (out > target) begin
        out     <= dn_next;
        settled <= (dn_next == target);
        st      <= ST_DOWN;
      end else begin
        settled <= 1'b1;
        st      <= ST_IDLE;
      end
    end
    // Without ce, everything holds. This includes FROZEN after hold drops:
    // the state is only re-evaluated on the next ce.
  end

  assign state = st;

endmodule

// File: tb/tb_ref_slew_l1.sv
// Directed testbench for ref_slew_l1. The expected values are hand-computed
// constants, plus a tiny clamp model for the long ramps.
module tb_ref_slew_l1;

  localparam int W = 32;

  logic                aclk;
  logic                resetn;
  logic                ce;
  logic signed [W-1:0] target;
  logic        [W-1:0] step;
  logic                hold;
  logic                preset;
  logic signed [W-1:0] out;
  logic                settled;
  logic        [1:0]   state;

  int n_checks = 0;
  int n_errors = 0;

  ref_slew_l1 #(.DATA_WIDTH(32), .DATA_WIDTH_DECIMAL(22)) dut (
    .aclk    (aclk),
    .resetn  (resetn),
    .ce      (ce),
    .target  (target),
    .step    (step),
    .hold    (hold),
    .preset  (preset),
    .out     (out),
    .settled (settled),
    .state   (state)
  );

  // Clock and reset.
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Driver tasks. Inputs change #1 after the rising edge, and outputs are
  // sampled at the same point.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic pulse_ce();
    ce = 1'b1;
    tick();
    ce = 1'b0;
    tick();
  endtask

  task automatic do_preset(input logic signed [W-1:0] v);
    target = v;
    preset = 1'b1;
    tick();
    preset = 1'b0;
  endtask

  // Scoreboard check.
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  longint exp_out;
  longint tgt_l;
  longint stp_l;

  initial begin
    resetn = 1'b0;
    ce     = 1'b0;
    target = '0;
    step   = '0;
    hold   = 1'b0;
    preset = 1'b0;
    tick();
    tick();
    check("rst_out", out, 0);
    check("rst_settled", {31'd0, settled}, 0);
    check("rst_state", {30'd0, state}, 0);

    // After reset, settled waits for the first ce, even with target == 0.
    resetn = 1'b1;
    tick();
    check("post_rst_no_ce_settled", {31'd0, settled}, 0);
    pulse_ce();
    check("first_ce_settled", {31'd0, settled}, 1);
    check("first_ce_state", {30'd0, state}, 0);

    // Up-ramp to 150.0 with step 0.01.
    target  = 629145600;
    step    = 41943;
    tgt_l   = 629145600;
    stp_l   = 41943;
    exp_out = 0;
    for (int k = 1; k <= 15001; k++) begin
      pulse_ce();
      exp_out = (exp_out + stp_l > tgt_l) ? tgt_l : exp_out + stp_l;
      if (k == 1) begin
        check("up_first_out", out, 41943);
        check("up_first_state", {30'd0, state}, 1);
        check("up_first_settled", {31'd0, settled}, 0);
      end
      if (k % 1000 == 0 || k >= 14999) check("up_ramp_out", out, exp_out[W-1:0]);
    end
    check("up_final_out", out, 629145600);
    check("up_final_settled", {31'd0, settled}, 1);
    check("up_final_state", {30'd0, state}, 1);
    pulse_ce();
    check("up_idle_out", out, 629145600);
    check("up_idle_state", {30'd0, state}, 0);
    check("up_idle_settled", {31'd0, settled}, 1);

    // Down-ramp to 100.0.
    target = 419430400;
    tgt_l  = 419430400;
    for (int k = 1; k <= 5001; k++) begin
      pulse_ce();
      exp_out = (exp_out - stp_l < tgt_l) ? tgt_l : exp_out - stp_l;
      if (k == 1) begin
        check("dn_first_out", out, 629145600 - 41943);
        check("dn_first_state", {30'd0, state}, 2);
      end
      if (k % 500 == 0 || k >= 5000) check("dn_ramp_out", out, exp_out[W-1:0]);
    end
    check("dn_final_out", out, 419430400);
    check("dn_final_settled", {31'd0, settled}, 1);
    pulse_ce();
    check("dn_idle_state", {30'd0, state}, 0);

    // Hold in the middle of a ramp.
    target = 419849830;
    repeat (3) pulse_ce();
    check("pre_hold_out", out, 419556229);
    check("pre_hold_state", {30'd0, state}, 1);
    hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      pulse_ce();
      check("hold_out", out, 419556229);
      check("hold_state", {30'd0, state}, 3);
    end
    check("hold_settled", {31'd0, settled}, 0);
    hold = 1'b0;
    tick();
    check("unhold_no_ce_state", {30'd0, state}, 3);
    pulse_ce();
    check("unhold_ce_out", out, 419598172);
    check("unhold_ce_state", {30'd0, state}, 1);

    // Preset wins over a simultaneous ce and hold.
    target = -209715200;
    preset = 1'b1;
    ce     = 1'b1;
    hold   = 1'b1;
    tick();
    preset = 1'b0;
    ce     = 1'b0;
    hold   = 1'b0;
    check("preset_out", out, -209715200);
    check("preset_settled", {31'd0, settled}, 1);
    check("preset_state", {30'd0, state}, 0);

    // The step MSB is ignored, and step zero means no movement.
    do_preset(0);
    target = 100;
    step   = 32'h8000_0001;
    pulse_ce();
    check("step_msb_out", out, 1);
    step = 0;
    pulse_ce();
    check("step0_out", out, 1);
    check("step0_state", {30'd0, state}, 1);
    check("step0_settled", {31'd0, settled}, 0);

    // Clamp on the last step, then a reversal within a single ce.
    step = 100;
    pulse_ce();
    check("clamp_out", out, 100);
    check("clamp_settled", {31'd0, settled}, 1);
    target = -50;
    pulse_ce();
    check("rev_dn_out", out, 0);
    check("rev_dn_state", {30'd0, state}, 2);
    target = 80;
    pulse_ce();
    check("rev_up_out", out, 80);
    check("rev_up_state", {30'd0, state}, 1);

    // Extremes: no sign wrap toward max positive or most negative.
    do_preset(32'sh7FFF_FF00);
    target = 32'sh7FFF_FFFF;
    step   = 32'h7FFF_FFFF;
    pulse_ce();
    check("max_pos_out", out, 32'h7FFF_FFFF);
    check("max_pos_settled", {31'd0, settled}, 1);
    do_preset(32'sh8000_0100);
    target = 32'sh8000_0000;
    pulse_ce();
    check("max_neg_out", out, 32'h8000_0000);
    check("max_neg_state", {30'd0, state}, 2);
    check("max_neg_settled", {31'd0, settled}, 1);

    // Reset during a down-ramp, then the ramp restarts from zero.
    do_preset(1000);
    target = 0;
    step   = 100;
    pulse_ce();
    pulse_ce();
    check("dn_mid_out", out, 800);
    resetn = 1'b0;
    ce     = 1'b1;
    tick();
    ce     = 1'b0;
    check("rst_mid_out", out, 0);
    check("rst_mid_state", {30'd0, state}, 0);
    check("rst_mid_settled", {31'd0, settled}, 0);
    resetn = 1'b1;
    target = 1000;
    pulse_ce();
    check("restart_out", out, 100);
    check("restart_state", {30'd0, state}, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
